timer_arb: RTL
==============

TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one countdown timer (2..8).
REQ-002 Parameter CNT_W, default 8: duration/counter width in bits.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  NUM_REQ  per-requester timer request, level.
REQ-006 i_dur  input  NUM_REQ*CNT_W  packed durations; slice k = bits [k*CNT_W +: CNT_W].
REQ-007 i_tick  input  1  count enable (prescaler strobe); decrement only when high.
REQ-008 o_gnt  output  NUM_REQ  one-hot grant, high while owner's interval runs.
REQ-009 o_done  output  NUM_REQ  one-cycle pulse on owner's bit at interval end.
REQ-010 o_busy  output  1  high in LOAD, COUNT and DONE states.
REQ-011 o_owner  output  $clog2(NUM_REQ)  index of current/last owner.
REQ-012 o_cnt_val  output  CNT_W  live counter value.

Function
REQ-013 FSM states IDLE, LOAD, COUNT, DONE; all outputs registered.
REQ-014 IDLE: if any i_req bit high, select winner round-robin starting at (last_owner+1) mod NUM_REQ, wrapping; go LOAD; else stay IDLE.
REQ-015 LOAD (one cycle): capture winner into o_owner, load counter with winner's i_dur slice, assert o_gnt[winner]; go COUNT.
REQ-016 i_dur sampled only in LOAD; later changes ignored for that interval.
REQ-017 COUNT: on i_tick with counter > 1, decrement by 1; on i_tick with counter <= 1, set counter 0 and go DONE; no i_tick holds value.
REQ-018 Duration 0 behaves as duration 1 (ends on first tick in COUNT).
REQ-019 Interval length = exactly max(dur,1) i_tick strobes seen in COUNT.
REQ-020 DONE (one cycle): o_done[owner]=1, o_gnt=0, last_owner<=owner; go IDLE.
REQ-021 Minimum gap DONE->next LOAD = one IDLE cycle; o_busy low in that cycle.
REQ-022 Requester still asserting i_req after its o_done is re-granted only if no other requester is pending (round-robin fairness).
REQ-023 Counter never wraps below 0 nor underflows.
REQ-024 o_gnt and o_done always zero or one-hot; never both set same cycle.

Reset
REQ-025 i_rst high at a rising edge forces IDLE regardless of state, including mid-COUNT.
REQ-026 Reset values: o_gnt=0, o_done=0, o_busy=0, o_cnt_val=0, o_owner=0, last_owner=NUM_REQ-1 (first grant favours requester 0).
REQ-027 Interval interrupted by reset produces no o_done pulse.
REQ-028 i_rst has priority over all other inputs in same cycle.

Configuration
REQ-029 Macro TIMER_ARB_ABORT_EN.
REQ-030 Defined: in COUNT, if i_req[owner] is low at a clock edge, go IDLE directly, o_gnt=0, no o_done, last_owner<=owner, counter cleared to 0.
REQ-031 Not defined: i_req[owner] ignored after LOAD; interval always runs to DONE.

Verification
REQ-032 Reset then i_req=4'b0001, dur0=3, i_tick always high -> o_gnt=0001 for LOAD + 3 COUNT cycles, o_done=0001 pulse next cycle, o_busy low one cycle later.
REQ-033 i_req=4'b1111 held, all dur=1 -> grant order 0,1,2,3,0; each o_done on matching bit.
REQ-034 dur=0 on requester 2 alone, i_tick pulsed every 4th cycle -> exactly one tick consumed before o_done=0100.
REQ-035 i_rst asserted during COUNT with counter=5 -> next cycle all outputs at reset values, no o_done ever pulses.
REQ-036 TIMER_ARB_ABORT_EN defined, owner 1 drops i_req mid-COUNT (counter=6) -> IDLE next cycle, o_gnt=0, no o_done; undefined build -> interval completes with o_done=0010.
REQ-037 dur changed during COUNT from 5 to 2 -> interval still lasts 5 ticks.

Source files
------------

// File: rtl/timer_arb.sv
// Round-robin arbiter in front of one shared countdown timer (IDLE/LOAD/COUNT/DONE).
// Optional TIMER_ARB_ABORT_EN: owner dropping its request mid-count returns to IDLE without o_done.
module timer_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_dur,
  input  logic                     i_tick,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic [OW-1:0]            o_owner,
  output logic [CNT_W-1:0]         o_cnt_val,
  output logic [1:0]               o_dbg_state
);

  // Request/grant: i_req is a level; a request is taken only in IDLE, o_gnt stays
  // high from LOAD through the last COUNT cycle, and o_done pulses once at the end.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   winner;
  logic            found;
  logic            abort_now;
  logic [CNT_W-1:0] dur_sel;

  assign o_dbg_state = state;
  assign dur_sel     = i_dur[int'(o_owner)*CNT_W +: CNT_W];

  // Search starts one past the previous owner so a persistent requester yields.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_owner) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

`ifdef TIMER_ARB_ABORT_EN
  assign abort_now = !i_req[o_owner];
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      o_gnt      <= '0;
      o_done     <= '0;
      o_busy     <= 1'b0;
      o_owner    <= '0;
      o_cnt_val  <= '0;
      last_owner <= OW'(NUM_REQ - 1);
    end else begin
      o_done <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state   <= S_LOAD;
            o_owner <= winner;
            o_gnt   <= NUM_REQ'(1) << winner;
            o_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          o_cnt_val <= dur_sel;
          state     <= S_COUNT;
        end
        S_COUNT: begin
          if (abort_now) begin
            state      <= S_IDLE;
            o_gnt      <= '0;
            o_busy     <= 1'b0;
            o_cnt_val  <= '0;
            last_owner <= o_owner;
          end else if (i_tick) begin
            // A loaded zero ends on the first tick, same as a loaded one.
            if (o_cnt_val > CNT_W'(1)) begin
              o_cnt_val <= o_cnt_val - CNT_W'(1);
            end else begin
              o_cnt_val  <= '0;
              state      <= S_DONE;
              o_gnt      <= '0;
              o_done     <= o_gnt;
              last_owner <= o_owner;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
